uart_cmd_rx: RTL and testbench

//   Host-to-board UART receiver and command decoder, the return path of the UART transmitter.
//   - Receives 8N1 serial bytes on rxd with 16x oversampling.
//   - Parses framed commands and drives the display/processing select and transmit request.
//   - Sits beside the transmitter in the top level, so a PC can change modes and trigger

---
 rtl/uart_cmd_rx.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver with 16x oversampling plus a small framed
// command parser that drives the mode select and the frame-dump request.
//
// Handshake: every output strobe (rx_valid, frame_err, transmit_req, cmd_err)
// is a registered single-cycle pulse with no ready/backpressure; a consumer
// must take rx_data in the same cycle rx_valid is high. rx_data holds the last
// good byte until the next good byte replaces it.
module uart_cmd_rx #(
  parameter int         CLK_HZ   = 100_000_000,
  parameter int         BAUD     = 115200,
  parameter logic [2:0] SEL_INIT = 3'b000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [2:0] output_select,
  output logic       transmit_req,
  output logic       cmd_err
);

  // Clocks per oversample tick, rounded to nearest; never below one clock.
  localparam int DIV_RAW = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [7:0] BYTE_SYNC   = 8'hA5;
  localparam logic [7:0] BYTE_SETSEL = 8'h01;
  localparam logic [7:0] BYTE_DUMP   = 8'h02;
  localparam logic [7:0] BYTE_DEFSEL = 8'h03;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    P_HUNT = 2'd0,
    P_CMD  = 2'd1,
    P_ARG  = 2'd2
  } p_state_e;

  // ---------------------------------------------------------------------
  // Input synchroniser and oversample tick divider
  // ---------------------------------------------------------------------
  logic             rxd_s1_q, rxd_s1_d;
  logic             rxd_s2_q, rxd_s2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic             rxs;

  assign rxs  = rxd_s2_q;
  assign tick = (div_q == DIV_W'(DIV - 1));

  // Next values for the synchroniser chain and the free-running divider.
  always_comb begin
    rxd_s1_d = rxd;
    rxd_s2_d = rxd_s1_q;
    div_d    = tick ? '0 : div_q + 1'b1;
  end

  // Sync flops preset to idle-high so reset never looks like a start bit edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
      div_q    <= '0;
    end else begin
      rxd_s1_q <= rxd_s1_d;
      rxd_s2_q <= rxd_s2_d;
      div_q    <= div_d;
    end
  end

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] sub_q, sub_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       frame_err_q, frame_err_d;

  // Receive state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rx_state_q <= RX_IDLE;
    end else begin
      rx_state_q <= rx_state_d;
    end
  end

  // Receive next-state: sampling decisions happen on ticks, BREAK exits on any clock.
  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE: begin
        if (tick && !rxs) rx_state_d = RX_START;
      end
      RX_START: begin
        // Mid start bit: a high line here was only a glitch.
        if (tick && (sub_q == 4'd7)) rx_state_d = rxs ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (tick && (sub_q == 4'd15) && (bit_q == 3'd7)) rx_state_d = RX_STOP;
      end
      RX_STOP: begin
        // Leaving at mid stop bit gives a half bit of slack for the next start.
        if (tick && (sub_q == 4'd15)) rx_state_d = rxs ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: begin
        if (rxs) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receive datapath and strobes: bit counters, shift register, byte/error pulses.
  always_comb begin
    sub_d       = sub_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (tick && !rxs) begin
          sub_d = 4'd0;
          bit_d = 3'd0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (sub_q == 4'd7) begin
            sub_d = 4'd0;
            bit_d = 3'd0;
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (sub_q == 4'd15) begin
            // LSB arrives first, so shift in from the top.
            shreg_d = {rxs, shreg_q[7:1]};
            sub_d   = 4'd0;
            bit_d   = bit_q + 3'd1;
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (sub_q == 4'd15) begin
            sub_d = 4'd0;
            if (rxs) begin
              rx_data_d  = shreg_q;
              rx_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
      RX_BREAK: begin
        sub_d = 4'd0;
      end
      default: begin
        sub_d = 4'd0;
        bit_d = 3'd0;
      end
    endcase
  end

  // Receive datapath registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sub_q       <= 4'd0;
      bit_q       <= 3'd0;
      shreg_q     <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sub_q       <= sub_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Command parser: A5 <cmd> [arg]
  // ---------------------------------------------------------------------
  p_state_e   p_state_q, p_state_d;
  logic [2:0] sel_q, sel_d;
  logic       treq_q, treq_d;
  logic       cerr_q, cerr_d;

  // Parser state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      p_state_q <= P_HUNT;
    end else begin
      p_state_q <= p_state_d;
    end
  end

  // Parser next-state: steps once per good byte, a framing error forces a resync.
  always_comb begin
    p_state_d = p_state_q;
    if (frame_err_q) begin
      p_state_d = P_HUNT;
    end else if (rx_valid_q) begin
      case (p_state_q)
        P_HUNT: begin
          if (rx_data_q == BYTE_SYNC) p_state_d = P_CMD;
        end
        P_CMD: begin
          case (rx_data_q)
            BYTE_SETSEL: p_state_d = P_ARG;
            BYTE_SYNC:   p_state_d = P_CMD;
            default:     p_state_d = P_HUNT;
          endcase
        end
        P_ARG:   p_state_d = P_HUNT;
        default: p_state_d = P_HUNT;
      endcase
    end
  end

  // Parser outputs: mode select update and command pulses.
  always_comb begin
    sel_d  = sel_q;
    treq_d = 1'b0;
    cerr_d = 1'b0;
    if (!frame_err_q && rx_valid_q) begin
      case (p_state_q)
        P_CMD: begin
          case (rx_data_q)
            BYTE_SETSEL: sel_d  = sel_q;
            BYTE_SYNC:   sel_d  = sel_q;
            BYTE_DUMP:   treq_d = 1'b1;
            BYTE_DEFSEL: sel_d  = SEL_INIT;
            default:     cerr_d = 1'b1;
          endcase
        end
        P_ARG: begin
          // Only three select bits exist; upper argument bits are don't-care.
          sel_d = rx_data_q[2:0];
        end
        default: sel_d = sel_q;
      endcase
    end
  end

  // Parser output registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sel_q  <= SEL_INIT;
      treq_q <= 1'b0;
      cerr_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      treq_q <= treq_d;
      cerr_q <= cerr_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign frame_err     = frame_err_q;
  assign output_select = sel_q;
  assign transmit_req  = treq_q;
  assign cmd_err       = cerr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx at 16 MHz / 250 kbaud (64 clocks per bit).
module tb_uart_cmd_rx;

  localparam int         CLK_HZ   = 16_000_000;
  localparam int         BAUD     = 250_000;
  localparam logic [2:0] SEL_INIT = 3'b010;
  localparam int         BIT_CLKS = 64;

  logic       clk;
  logic       clr;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic [2:0] output_select;
  logic       transmit_req;
  logic       cmd_err;

  uart_cmd_rx #(
    .CLK_HZ  (CLK_HZ),
    .BAUD    (BAUD),
    .SEL_INIT(SEL_INIT)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_err    (frame_err),
    .output_select(output_select),
    .transmit_req (transmit_req),
    .cmd_err      (cmd_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Entry: {transmit_req, cmd_err, select_after[2:0], data[7:0]}
  logic [12:0] exp_q[$];
  int          m_ps;      // 0 waiting for sync, 1 expecting command, 2 expecting argument
  logic [2:0]  m_sel;
  int          m_good_total = 0;
  int          m_ferr_total = 0;
  int          m_treq_total = 0;
  int          m_cerr_total = 0;

  task automatic model_reset();
    m_ps  = 0;
    m_sel = SEL_INIT;
    exp_q.delete();
  endtask

  task automatic model_good_byte(input logic [7:0] b);
    logic t;
    logic c;
    t = 1'b0;
    c = 1'b0;
    if (m_ps == 0) begin
      if (b == 8'hA5) m_ps = 1;
    end else if (m_ps == 1) begin
      if (b == 8'h01) m_ps = 2;
      else if (b == 8'h02) begin t = 1'b1; m_ps = 0; end
      else if (b == 8'h03) begin m_sel = SEL_INIT; m_ps = 0; end
      else if (b == 8'hA5) m_ps = 1;
      else begin c = 1'b1; m_ps = 0; end
    end else begin
      m_sel = b[2:0];
      m_ps  = 0;
    end
    m_good_total++;
    if (t) m_treq_total++;
    if (c) m_cerr_total++;
    exp_q.push_back({t, c, m_sel, b});
  endtask

  task automatic model_frame_error();
    m_ferr_total++;
    m_ps = 0;
  endtask

  // ---------------- scoreboard monitor ----------------
  int          rxv_cnt = 0;
  int          ferr_cnt = 0;
  int          treq_cnt = 0;
  int          cerr_cnt = 0;
  int          ovl_cnt = 0;
  int          spur_cnt = 0;
  logic        pend = 1'b0;
  logic [12:0] cur;

  always @(negedge clk) begin
    if (clr) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check_val("sel_after_byte", output_select, cur[10:8]);
        check_val("treq_after_byte", transmit_req, cur[12]);
        check_val("cerr_after_byte", cmd_err, cur[11]);
        pend = 1'b0;
      end
      if (rx_valid) begin
        rxv_cnt++;
        if (exp_q.size() == 0) begin
          spur_cnt++;
        end else begin
          cur = exp_q.pop_front();
          check_val("rx_data", rx_data, cur[7:0]);
          pend = 1'b1;
        end
      end
      if (frame_err)    ferr_cnt++;
      if (transmit_req) treq_cnt++;
      if (cmd_err)      cerr_cnt++;
      if ((int'(rx_valid) + int'(frame_err) + int'(transmit_req) + int'(cmd_err)) > 1) ovl_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) model_good_byte(b);
    else model_frame_error();
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic checkpoint(input string tag);
    rxd = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_val({tag, "_drain"}, exp_q.size(), 0);
    check_val({tag, "_rxv_count"}, rxv_cnt, m_good_total);
    check_val({tag, "_ferr_count"}, ferr_cnt, m_ferr_total);
    check_val({tag, "_treq_count"}, treq_cnt, m_treq_total);
    check_val({tag, "_cerr_count"}, cerr_cnt, m_cerr_total);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rx_data"}, rx_data, 8'h00);
    check_val({tag, "_rx_valid"}, rx_valid, 1'b0);
    check_val({tag, "_frame_err"}, frame_err, 1'b0);
    check_val({tag, "_sel"}, output_select, SEL_INIT);
    check_val({tag, "_treq"}, transmit_req, 1'b0);
    check_val({tag, "_cerr"}, cmd_err, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] sel_before;
    logic [7:0] b;
    int         r;
    logic       bad;

    model_reset();
    clr = 1'b1;
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    clr = 1'b0;
    idle(50);

    // Back-to-back bytes with no idle gap.
    send_frame(8'h55, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    checkpoint("b2b");
    check_val("b2b_last_data", rx_data, 8'hFF);

    // Short low glitch must be rejected; a following byte proves the FSM is idle.
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    idle(200);
    checkpoint("glitch");
    send_frame(8'h5A, 1'b1);
    checkpoint("after_glitch");

    // Bad stop bit, line held low, then a good byte.
    send_frame(8'h3C, 1'b0);
    rxd = 1'b0;
    repeat (500) @(negedge clk);
    idle(100);
    check_val("break_data_kept", rx_data, 8'h5A);
    send_frame(8'hA5, 1'b1);
    checkpoint("break");

    // Set select, then restore it to the reset value.
    send_frame(8'hA5, 1'b1);
    send_frame(8'h01, 1'b1);
    send_frame(8'h06, 1'b1);
    checkpoint("setsel");
    check_val("setsel_value", output_select, 3'b110);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h03, 1'b1);
    checkpoint("defsel");
    check_val("defsel_value", output_select, SEL_INIT);

    // Dump request, unknown command, and a bare command byte.
    send_frame(8'hA5, 1'b1);
    send_frame(8'h02, 1'b1);
    checkpoint("dump");
    sel_before = output_select;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h7E, 1'b1);
    checkpoint("badcmd");
    check_val("badcmd_sel_kept", output_select, sel_before);
    send_frame(8'h02, 1'b1);
    idle(20);
    checkpoint("bare_cmd");

    // Randomized command traffic with occasional framing errors.
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: b = 8'hA5;
        1: b = 8'h01;
        2: b = 8'h02;
        3: b = 8'h03;
        default: b = 8'($urandom_range(0, 255));
      endcase
      bad = ($urandom_range(0, 9) == 0);
      if (bad) begin
        send_frame(b, 1'b0);
        rxd = 1'b0;
        repeat ($urandom_range(10, 150)) @(negedge clk);
        idle(80);
      end else begin
        send_frame(b, 1'b1);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 150));
      end
    end
    checkpoint("random");

    // Move select away from its reset value, then reset in the middle of a byte.
    send_frame(8'hA5, 1'b1);
    send_frame(8'h01, 1'b1);
    send_frame(8'h05, 1'b1);
    checkpoint("pre_reset");
    check_val("pre_reset_sel", output_select, 3'b101);
    b = 8'h5A;
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = b[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    @(posedge clk);
    clr = 1'b1;
    rxd = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("midbyte_reset");
    clr = 1'b0;
    idle(100);
    send_frame(8'h81, 1'b1);
    checkpoint("post_reset");
    check_val("post_reset_data", rx_data, 8'h81);

    check_val("spurious_rx_valid", spur_cnt, 0);
    check_val("pulse_overlap", ovl_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
